// File: rtl/id_ex_stage_reg_if.sv
// ID/EX stage bundle: decoded ID fields in, registered EX copies out.
// Hazard stall and bubble count travel with the bundle.
interface id_ex_stage_reg_if #(
  parameter int XLEN  = 32,
  parameter int RA_W  = 5,
  parameter int CNT_W = 16
);
  logic            valid_i;
  logic            branch_i;
  logic            mem_rd_i;
  logic            mem_to_reg_i;
  logic            mem_wr_i;
  logic            a_sel_i;
  logic            b_sel_i;
  logic            reg_wr_i;
  logic [1:0]      alu_op_i;
  logic [3:0]      funct_i;
  logic [XLEN-1:0] pc_i;
  logic [XLEN-1:0] rs1_data_i;
  logic [XLEN-1:0] rs2_data_i;
  logic [XLEN-1:0] imm_i;
  logic [RA_W-1:0] rs1_addr_i;
  logic [RA_W-1:0] rs2_addr_i;
  logic [RA_W-1:0] rd_addr_i;
  logic            flush_i;
  logic            hold_i;

  logic             valid_o;
  logic             branch_o;
  logic             mem_rd_o;
  logic             mem_to_reg_o;
  logic             mem_wr_o;
  logic             a_sel_o;
  logic             b_sel_o;
  logic             reg_wr_o;
  logic [1:0]       alu_op_o;
  logic [3:0]       funct_o;
  logic [XLEN-1:0]  pc_o;
  logic [XLEN-1:0]  rs1_data_o;
  logic [XLEN-1:0]  rs2_data_o;
  logic [XLEN-1:0]  imm_o;
  logic [RA_W-1:0]  rs1_addr_o;
  logic [RA_W-1:0]  rs2_addr_o;
  logic [RA_W-1:0]  rd_addr_o;
  logic             stall_o;
  logic [CNT_W-1:0] bubble_cnt_o;

  modport master (
    output valid_i, branch_i, mem_rd_i,
    output mem_to_reg_i, mem_wr_i, a_sel_i,
    output b_sel_i, reg_wr_i, alu_op_i,
    output funct_i, pc_i, rs1_data_i,
    output rs2_data_i, imm_i, rs1_addr_i,
    output rs2_addr_i, rd_addr_i,
    output flush_i, hold_i,
    input  valid_o, branch_o, mem_rd_o,
    input  mem_to_reg_o, mem_wr_o, a_sel_o,
    input  b_sel_o, reg_wr_o, alu_op_o,
    input  funct_o, pc_o, rs1_data_o,
    input  rs2_data_o, imm_o, rs1_addr_o,
    input  rs2_addr_o, rd_addr_o,
    input  stall_o, bubble_cnt_o
  );

  modport slave (
    input  valid_i, branch_i, mem_rd_i,
    input  mem_to_reg_i, mem_wr_i, a_sel_i,
    input  b_sel_i, reg_wr_i, alu_op_i,
    input  funct_i, pc_i, rs1_data_i,
    input  rs2_data_i, imm_i, rs1_addr_i,
    input  rs2_addr_i, rd_addr_i,
    input  flush_i, hold_i,
    output valid_o, branch_o, mem_rd_o,
    output mem_to_reg_o, mem_wr_o, a_sel_o,
    output b_sel_o, reg_wr_o, alu_op_o,
    output funct_o, pc_o, rs1_data_o,
    output rs2_data_o, imm_o, rs1_addr_o,
    output rs2_addr_o, rd_addr_o,
    output stall_o, bubble_cnt_o
  );
endinterface

// File: rtl/id_ex_stage_reg.sv
// ID/EX pipeline register with load-use bubble insertion.
// Flush beats hold beats load-use; bubbles are counted (saturating).
module id_ex_stage_reg #(
  parameter int XLEN  = 32,
  parameter int RA_W  = 5,
  parameter int CNT_W = 16
)(
  input logic              clk_i,
  input logic              rst_i,
  id_ex_stage_reg_if.slave bus
);

  logic [8:0]       ctrl_in;
  logic [8:0]       ctrl_q;
  logic             valid_q;
  logic [CNT_W-1:0] cnt_q;
  logic             uses_rs1;
  logic             uses_rs2;
  logic             rs1_hit;
  logic             rs2_hit;
  logic             load_use;
  logic             advance;
  logic             bubble;

  assign ctrl_in = {bus.branch_i,
                    bus.mem_rd_i,
                    bus.mem_to_reg_i,
                    bus.mem_wr_i,
                    bus.a_sel_i,
                    bus.b_sel_i,
                    bus.reg_wr_i,
                    bus.alu_op_i};

  // Hazard detection against the load sitting in EX.
  always_comb begin
    uses_rs1 = (bus.alu_op_i != 2'b11)
             & ~bus.a_sel_i;
    uses_rs2 = ~bus.b_sel_i | bus.mem_wr_i;
    rs1_hit  = uses_rs1
             & (bus.rs1_addr_i == bus.rd_addr_o);
    rs2_hit  = uses_rs2
             & (bus.rs2_addr_i == bus.rd_addr_o);
    load_use = valid_q & ctrl_q[7]
             & (bus.rd_addr_o != {RA_W{1'b0}})
             & bus.valid_i
             & (rs1_hit | rs2_hit);
  end

  assign advance = bus.flush_i | ~bus.hold_i;
  assign bubble  = bus.flush_i | load_use;

  assign bus.stall_o = bus.hold_i
                     | (load_use & ~bus.flush_i);

  // Valid bit and control bundle; a bubble clears both.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_q <= 1'b0;
      ctrl_q  <= 9'd0;
    end else if (advance) begin
      if (bubble) begin
        valid_q <= 1'b0;
        ctrl_q  <= 9'd0;
      end else begin
        valid_q <= bus.valid_i;
        ctrl_q  <= bus.valid_i ? ctrl_in : 9'd0;
      end
    end
  end

  // Datapath and address fields; bubbles leave them untouched.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      bus.funct_o    <= 4'd0;
      bus.pc_o       <= {XLEN{1'b0}};
      bus.rs1_data_o <= {XLEN{1'b0}};
      bus.rs2_data_o <= {XLEN{1'b0}};
      bus.imm_o      <= {XLEN{1'b0}};
      bus.rs1_addr_o <= {RA_W{1'b0}};
      bus.rs2_addr_o <= {RA_W{1'b0}};
      bus.rd_addr_o  <= {RA_W{1'b0}};
    end else if (advance && !bubble) begin
      bus.funct_o    <= bus.funct_i;
      bus.pc_o       <= bus.pc_i;
      bus.rs1_data_o <= bus.rs1_data_i;
      bus.rs2_data_o <= bus.rs2_data_i;
      bus.imm_o      <= bus.imm_i;
      bus.rs1_addr_o <= bus.rs1_addr_i;
      bus.rs2_addr_o <= bus.rs2_addr_i;
      bus.rd_addr_o  <= bus.rd_addr_i;
    end
  end

  // Count load-use bubbles only; flush and hold do not count.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= {CNT_W{1'b0}};
    end else if (!bus.flush_i && !bus.hold_i
                 && load_use && !(&cnt_q)) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign bus.valid_o      = valid_q;
  assign bus.branch_o     = ctrl_q[8];
  assign bus.mem_rd_o     = ctrl_q[7];
  assign bus.mem_to_reg_o = ctrl_q[6];
  assign bus.mem_wr_o     = ctrl_q[5];
  assign bus.a_sel_o      = ctrl_q[4];
  assign bus.b_sel_o      = ctrl_q[3];
  assign bus.reg_wr_o     = ctrl_q[2];
  assign bus.alu_op_o     = ctrl_q[1:0];
  assign bus.bubble_cnt_o = cnt_q;

endmodule

// File: tb/tb_id_ex_stage_reg.sv
// Directed bench for id_ex_stage_reg.
// A second 3-bit-counter instance exercises saturation.
module tb_id_ex_stage_reg;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  id_ex_stage_reg_if bus ();
  id_ex_stage_reg_if #(.CNT_W(3)) sbus ();

  id_ex_stage_reg dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  id_ex_stage_reg #(.CNT_W(3)) sdut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (sbus)
  );

  int total = 0;
  int bad = 0;
  int exp_cnt = 0;

  // {branch,mem_rd,mem_to_reg,mem_wr,a_sel,b_sel,reg_wr}
  localparam logic [6:0] C_R   = 7'b0000001;
  localparam logic [6:0] C_LD  = 7'b0110011;
  localparam logic [6:0] C_ST  = 7'b0001010;
  localparam logic [6:0] C_IMM = 7'b0000011;
  localparam logic [6:0] C_ALL = 7'b1111111;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(
    input logic        v,
    input logic [6:0]  c,
    input logic [1:0]  op,
    input logic [4:0]  r1,
    input logic [4:0]  r2,
    input logic [4:0]  rd,
    input logic [31:0] pc,
    input logic        f,
    input logic        h
  );
    bus.valid_i      = v;
    bus.branch_i     = c[6];
    bus.mem_rd_i     = c[5];
    bus.mem_to_reg_i = c[4];
    bus.mem_wr_i     = c[3];
    bus.a_sel_i      = c[2];
    bus.b_sel_i      = c[1];
    bus.reg_wr_i     = c[0];
    bus.alu_op_i     = op;
    bus.funct_i      = pc[3:0];
    bus.pc_i         = pc;
    bus.rs1_data_i   = {16'h1111, pc[15:0]};
    bus.rs2_data_i   = {16'h2222, pc[15:0]};
    bus.imm_i        = {16'h3333, pc[15:0]};
    bus.rs1_addr_i   = r1;
    bus.rs2_addr_i   = r2;
    bus.rd_addr_i    = rd;
    bus.flush_i      = f;
    bus.hold_i       = h;
    sbus.valid_i      = v;
    sbus.branch_i     = c[6];
    sbus.mem_rd_i     = c[5];
    sbus.mem_to_reg_i = c[4];
    sbus.mem_wr_i     = c[3];
    sbus.a_sel_i      = c[2];
    sbus.b_sel_i      = c[1];
    sbus.reg_wr_i     = c[0];
    sbus.alu_op_i     = op;
    sbus.funct_i      = pc[3:0];
    sbus.pc_i         = pc;
    sbus.rs1_data_i   = {16'h1111, pc[15:0]};
    sbus.rs2_data_i   = {16'h2222, pc[15:0]};
    sbus.imm_i        = {16'h3333, pc[15:0]};
    sbus.rs1_addr_i   = r1;
    sbus.rs2_addr_i   = r2;
    sbus.rd_addr_i    = rd;
    sbus.flush_i      = f;
    sbus.hold_i       = h;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    drive(1, C_ALL, 2'b10, 5, 5, 5,
          32'hDEAD_BEEF, 0, 0);
    tick;
    tick;
    total++;
    if (bus.valid_o !== 1'b0 ||
        bus.reg_wr_o !== 1'b0 ||
        bus.mem_rd_o !== 1'b0 ||
        bus.branch_o !== 1'b0) begin
      bad++;
      $display("FAIL reset_ctrl got v=%b rw=%b mr=%b br=%b exp all 0",
               bus.valid_o, bus.reg_wr_o,
               bus.mem_rd_o, bus.branch_o);
    end
    total++;
    if (bus.pc_o !== 32'd0 ||
        bus.rs1_data_o !== 32'd0 ||
        bus.rd_addr_o !== 5'd0) begin
      bad++;
      $display("FAIL reset_data got pc=%h d1=%h rd=%0d exp 0",
               bus.pc_o, bus.rs1_data_o,
               bus.rd_addr_o);
    end
    total++;
    if (bus.bubble_cnt_o !== 16'd0 ||
        bus.stall_o !== 1'b0) begin
      bad++;
      $display("FAIL reset_cnt got cnt=%0d stall=%b exp 0 0",
               bus.bubble_cnt_o, bus.stall_o);
    end
    rst = 1'b0;
    exp_cnt = 0;
  endtask

  task automatic test_rtype;
    drive(1, C_R, 2'b10, 1, 2, 3,
          32'h0000_0105, 0, 0);
    #1;
    total++;
    if (bus.stall_o !== 1'b0) begin
      bad++;
      $display("FAIL rtype_stall got=%b exp=0",
               bus.stall_o);
    end
    tick;
    total++;
    if (bus.valid_o !== 1'b1 ||
        bus.alu_op_o !== 2'b10 ||
        bus.reg_wr_o !== 1'b1 ||
        bus.mem_rd_o !== 1'b0) begin
      bad++;
      $display("FAIL rtype_ctrl got v=%b op=%b rw=%b mr=%b exp 1 10 1 0",
               bus.valid_o, bus.alu_op_o,
               bus.reg_wr_o, bus.mem_rd_o);
    end
    total++;
    if (bus.pc_o !== 32'h0000_0105 ||
        bus.rs1_data_o !== 32'h1111_0105 ||
        bus.rs2_data_o !== 32'h2222_0105 ||
        bus.imm_o !== 32'h3333_0105 ||
        bus.funct_o !== 4'h5) begin
      bad++;
      $display("FAIL rtype_data got pc=%h d1=%h d2=%h imm=%h fn=%h",
               bus.pc_o, bus.rs1_data_o,
               bus.rs2_data_o, bus.imm_o,
               bus.funct_o);
    end
    total++;
    if (bus.rs1_addr_o !== 5'd1 ||
        bus.rs2_addr_o !== 5'd2 ||
        bus.rd_addr_o !== 5'd3) begin
      bad++;
      $display("FAIL rtype_addr got %0d %0d %0d exp 1 2 3",
               bus.rs1_addr_o, bus.rs2_addr_o,
               bus.rd_addr_o);
    end
  endtask

  task automatic test_load_use;
    drive(1, C_LD, 2'b00, 2, 0, 5,
          32'h110, 0, 0);
    tick;
    drive(1, C_R, 2'b10, 5, 6, 7,
          32'h120, 0, 0);
    #1;
    total++;
    if (bus.stall_o !== 1'b1) begin
      bad++;
      $display("FAIL lu_stall got=%b exp=1",
               bus.stall_o);
    end
    tick;
    exp_cnt++;
    total++;
    if (bus.valid_o !== 1'b0 ||
        bus.reg_wr_o !== 1'b0 ||
        bus.mem_rd_o !== 1'b0 ||
        bus.bubble_cnt_o !== 16'(exp_cnt)) begin
      bad++;
      $display("FAIL lu_bubble got v=%b rw=%b mr=%b cnt=%0d exp 0 0 0 %0d",
               bus.valid_o, bus.reg_wr_o,
               bus.mem_rd_o, bus.bubble_cnt_o,
               exp_cnt);
    end
    total++;
    if (bus.stall_o !== 1'b0) begin
      bad++;
      $display("FAIL lu_release got=%b exp=0",
               bus.stall_o);
    end
    tick;
    total++;
    if (bus.valid_o !== 1'b1 ||
        bus.rd_addr_o !== 5'd7 ||
        bus.pc_o !== 32'h120 ||
        bus.bubble_cnt_o !== 16'(exp_cnt)) begin
      bad++;
      $display("FAIL lu_advance got v=%b rd=%0d pc=%h cnt=%0d",
               bus.valid_o, bus.rd_addr_o,
               bus.pc_o, bus.bubble_cnt_o);
    end
  endtask

  task automatic test_no_hazard;
    drive(1, C_LD, 2'b00, 2, 0, 0,
          32'h130, 0, 0);
    tick;
    drive(1, C_R, 2'b10, 0, 0, 7,
          32'h140, 0, 0);
    #1;
    total++;
    if (bus.stall_o !== 1'b0) begin
      bad++;
      $display("FAIL x0_stall got=%b exp=0",
               bus.stall_o);
    end
    tick;
    total++;
    if (bus.valid_o !== 1'b1 ||
        bus.pc_o !== 32'h140) begin
      bad++;
      $display("FAIL x0_capture got v=%b pc=%h exp 1 140",
               bus.valid_o, bus.pc_o);
    end
    drive(1, C_LD, 2'b00, 2, 0, 5,
          32'h150, 0, 0);
    tick;
    drive(1, C_IMM, 2'b11, 5, 5, 5,
          32'h160, 0, 0);
    #1;
    total++;
    if (bus.stall_o !== 1'b0) begin
      bad++;
      $display("FAIL lui_stall got=%b exp=0",
               bus.stall_o);
    end
    tick;
    total++;
    if (bus.valid_o !== 1'b1 ||
        bus.alu_op_o !== 2'b11 ||
        bus.pc_o !== 32'h160) begin
      bad++;
      $display("FAIL lui_capture got v=%b op=%b pc=%h",
               bus.valid_o, bus.alu_op_o,
               bus.pc_o);
    end
  endtask

  task automatic test_store;
    drive(1, C_LD, 2'b00, 2, 0, 5,
          32'h170, 0, 0);
    tick;
    drive(1, C_ST, 2'b00, 1, 5, 9,
          32'h180, 0, 0);
    #1;
    total++;
    if (bus.stall_o !== 1'b1) begin
      bad++;
      $display("FAIL sw_stall got=%b exp=1",
               bus.stall_o);
    end
    tick;
    exp_cnt++;
    total++;
    if (bus.valid_o !== 1'b0 ||
        bus.mem_wr_o !== 1'b0 ||
        bus.bubble_cnt_o !== 16'(exp_cnt)) begin
      bad++;
      $display("FAIL sw_bubble got v=%b mw=%b cnt=%0d exp 0 0 %0d",
               bus.valid_o, bus.mem_wr_o,
               bus.bubble_cnt_o, exp_cnt);
    end
    tick;
    total++;
    if (bus.valid_o !== 1'b1 ||
        bus.mem_wr_o !== 1'b1) begin
      bad++;
      $display("FAIL sw_advance got v=%b mw=%b exp 1 1",
               bus.valid_o, bus.mem_wr_o);
    end
    drive(1, C_LD, 2'b00, 2, 0, 5,
          32'h190, 0, 0);
    tick;
    drive(1, C_IMM, 2'b10, 1, 5, 9,
          32'h1A0, 0, 0);
    #1;
    total++;
    if (bus.stall_o !== 1'b0) begin
      bad++;
      $display("FAIL addi_stall got=%b exp=0",
               bus.stall_o);
    end
    tick;
    total++;
    if (bus.valid_o !== 1'b1 ||
        bus.pc_o !== 32'h1A0) begin
      bad++;
      $display("FAIL addi_capture got v=%b pc=%h",
               bus.valid_o, bus.pc_o);
    end
  endtask

  task automatic test_flush;
    drive(1, C_LD, 2'b00, 2, 0, 5,
          32'h1B0, 0, 0);
    tick;
    drive(1, C_R, 2'b10, 5, 6, 7,
          32'h1C0, 1, 1);
    #1;
    total++;
    if (bus.stall_o !== 1'b1) begin
      bad++;
      $display("FAIL flush_hold_stall got=%b exp=1",
               bus.stall_o);
    end
    tick;
    total++;
    if (bus.valid_o !== 1'b0 ||
        bus.reg_wr_o !== 1'b0 ||
        bus.mem_rd_o !== 1'b0 ||
        bus.mem_to_reg_o !== 1'b0 ||
        bus.bubble_cnt_o !== 16'(exp_cnt)) begin
      bad++;
      $display("FAIL flush_bubble got v=%b rw=%b mr=%b cnt=%0d exp cnt=%0d",
               bus.valid_o, bus.reg_wr_o,
               bus.mem_rd_o, bus.bubble_cnt_o,
               exp_cnt);
    end
    drive(1, C_R, 2'b10, 1, 2, 3,
          32'h1D0, 1, 0);
    #1;
    total++;
    if (bus.stall_o !== 1'b0) begin
      bad++;
      $display("FAIL flush_only_stall got=%b exp=0",
               bus.stall_o);
    end
    tick;
    total++;
    if (bus.valid_o !== 1'b0 ||
        bus.reg_wr_o !== 1'b0) begin
      bad++;
      $display("FAIL flush_only got v=%b rw=%b exp 0 0",
               bus.valid_o, bus.reg_wr_o);
    end
  endtask

  task automatic test_hold;
    drive(1, C_R, 2'b10, 1, 2, 3,
          32'h200, 0, 0);
    tick;
    drive(1, C_LD, 2'b00, 2, 0, 5,
          32'h300, 0, 1);
    #1;
    total++;
    if (bus.stall_o !== 1'b1) begin
      bad++;
      $display("FAIL hold_stall got=%b exp=1",
               bus.stall_o);
    end
    tick;
    total++;
    if (bus.pc_o !== 32'h200 ||
        bus.alu_op_o !== 2'b10 ||
        bus.mem_rd_o !== 1'b0 ||
        bus.valid_o !== 1'b1) begin
      bad++;
      $display("FAIL hold_keep got pc=%h op=%b mr=%b v=%b",
               bus.pc_o, bus.alu_op_o,
               bus.mem_rd_o, bus.valid_o);
    end
    drive(1, C_LD, 2'b00, 2, 0, 5,
          32'h300, 0, 0);
    tick;
    drive(1, C_R, 2'b10, 5, 6, 7,
          32'h310, 0, 1);
    tick;
    total++;
    if (bus.valid_o !== 1'b1 ||
        bus.mem_rd_o !== 1'b1 ||
        bus.bubble_cnt_o !== 16'(exp_cnt)) begin
      bad++;
      $display("FAIL hold_lu got v=%b mr=%b cnt=%0d exp 1 1 %0d",
               bus.valid_o, bus.mem_rd_o,
               bus.bubble_cnt_o, exp_cnt);
    end
    drive(1, C_R, 2'b10, 5, 6, 7,
          32'h310, 0, 0);
    #1;
    total++;
    if (bus.stall_o !== 1'b1) begin
      bad++;
      $display("FAIL unhold_stall got=%b exp=1",
               bus.stall_o);
    end
    tick;
    exp_cnt++;
    total++;
    if (bus.valid_o !== 1'b0 ||
        bus.bubble_cnt_o !== 16'(exp_cnt)) begin
      bad++;
      $display("FAIL unhold_bubble got v=%b cnt=%0d exp 0 %0d",
               bus.valid_o, bus.bubble_cnt_o,
               exp_cnt);
    end
  endtask

  task automatic test_invalid;
    drive(0, C_ALL, 2'b11, 1, 2, 3,
          32'h500, 0, 0);
    tick;
    total++;
    if (bus.valid_o !== 1'b0 ||
        bus.reg_wr_o !== 1'b0 ||
        bus.mem_wr_o !== 1'b0 ||
        bus.branch_o !== 1'b0 ||
        bus.alu_op_o !== 2'b00 ||
        bus.pc_o !== 32'h500) begin
      bad++;
      $display("FAIL invalid got v=%b rw=%b mw=%b br=%b op=%b pc=%h",
               bus.valid_o, bus.reg_wr_o,
               bus.mem_wr_o, bus.branch_o,
               bus.alu_op_o, bus.pc_o);
    end
  endtask

  task automatic test_reset_mid;
    drive(1, C_LD, 2'b00, 2, 0, 5,
          32'h600, 0, 0);
    tick;
    rst = 1'b1;
    drive(1, C_R, 2'b10, 5, 6, 7,
          32'h610, 0, 1);
    tick;
    rst = 1'b0;
    exp_cnt = 0;
    drive(1, C_R, 2'b10, 5, 6, 7,
          32'h610, 0, 0);
    #1;
    total++;
    if (bus.stall_o !== 1'b0 ||
        bus.valid_o !== 1'b0 ||
        bus.bubble_cnt_o !== 16'd0) begin
      bad++;
      $display("FAIL reset_mid got stall=%b v=%b cnt=%0d exp 0 0 0",
               bus.stall_o, bus.valid_o,
               bus.bubble_cnt_o);
    end
    tick;
  endtask

  task automatic test_saturate;
    int sexp;
    rst = 1'b1;
    tick;
    rst = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      drive(1, C_LD, 2'b00, 2, 0, 5,
            32'h700, 0, 0);
      tick;
      drive(1, C_R, 2'b10, 5, 6, 7,
            32'h710, 0, 0);
      tick;
      sexp = (i > 7) ? 7 : i;
      total++;
      if (bus.bubble_cnt_o !== 16'(i) ||
          sbus.bubble_cnt_o !== 3'(sexp)) begin
        bad++;
        $display("FAIL sat_%0d got cnt=%0d small=%0d exp %0d %0d",
                 i, bus.bubble_cnt_o,
                 sbus.bubble_cnt_o, i, sexp);
      end
    end
    rst = 1'b1;
    tick;
    total++;
    if (sbus.bubble_cnt_o !== 3'd0 ||
        bus.bubble_cnt_o !== 16'd0 ||
        bus.valid_o !== 1'b0 ||
        bus.pc_o !== 32'd0) begin
      bad++;
      $display("FAIL sat_reset got small=%0d cnt=%0d v=%b pc=%h",
               sbus.bubble_cnt_o, bus.bubble_cnt_o,
               bus.valid_o, bus.pc_o);
    end
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    drive(0, 7'd0, 2'b00, 0, 0, 0,
          32'd0, 0, 0);
    test_reset;
    test_rtype;
    test_load_use;
    test_no_hazard;
    test_store;
    test_flush;
    test_hold;
    test_invalid;
    test_reset_mid;
    test_saturate;
    $display("test done: total=%0d bad=%0d",
             total, bad);
    $finish;
  end

endmodule
